// File: rtl/axi_reg_pkg.sv
// Shared definitions for the AXI register master/slave pair: default bus widths,
// AXI response codes and the master FSM state encoding.
package axi_reg_pkg;

  localparam int unsigned AXI_ADDR_W      = 32;
  localparam int unsigned AXI_DATA_W      = 32;
  localparam int unsigned AXI_ID_W        = 4;
  localparam int unsigned AXI_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } resp_t;

  // Master FSM encoding kept as plain constants so legacy code can match on raw values.
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StWr    = 3'd1;
  localparam state_t StWresp = 3'd2;
  localparam state_t StRd    = 3'd3;
  localparam state_t StRdata = 3'd4;
  localparam state_t StResp  = 3'd5;

endpackage

// File: rtl/axi_reg_master_if.sv
// AXI channel bundle between the register master and the register slave.
interface axi_reg_master_if
  import axi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned ID_W   = AXI_ID_W
) ();

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arvalid, input arready,
    input rid, rdata, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awvalid, output awready,
    input wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arvalid, output arready,
    output rid, rdata, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi_reg_watchdog.sv
// Per-transaction cycle counter for the AXI register master. Cleared on command
// accept, counts while a transaction is in flight, flags expiry on the cycle whose
// edge would be the TIMEOUT_CYC-th counted edge.
module axi_reg_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic areset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] r_count;

  assign o_expired = i_count && (r_count == CntW'(TIMEOUT_CYC - 1));

  // Counter advances only while busy and stops once the abort is taken.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_reg_master.sv
// Single-beat AXI master: one valid/ready command in, AW/W/B or AR/R traffic out,
// one response back. Optional watchdog abort enabled by AXI_MASTER_TIMEOUT_EN.
module axi_reg_master
  import axi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = AXI_ADDR_W,
  parameter int unsigned DATA_W      = AXI_DATA_W,
  parameter int unsigned ID_W        = AXI_ID_W,
  parameter int unsigned TIMEOUT_CYC = AXI_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]          o_rsp_resp,
  axi_reg_master_if.master    axi
);

  state_t              r_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic                r_bready;
  logic                r_rready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                w_expired;
  logic                w_unused;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic w_busy;
  assign w_busy = (r_state == StWr) || (r_state == StWresp) ||
                  (r_state == StRd) || (r_state == StRdata);

  axi_reg_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .areset   (areset),
    .i_clear  (i_cmd_valid && o_cmd_ready),
    .i_count  (w_busy),
    .o_expired(w_expired)
  );
  assign w_unused = axi.rlast;
`else
  assign w_expired = 1'b0;
  assign w_unused  = axi.rlast ^ (TIMEOUT_CYC == 0);
`endif

  assign o_cmd_ready = (r_state == StIdle);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;

  assign axi.awid    = r_id;
  assign axi.awaddr  = r_addr;
  assign axi.awvalid = r_awvalid;
  assign axi.wid     = r_id;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.arid    = r_id;
  assign axi.araddr  = r_addr;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  // Transaction FSM: command capture, channel handshakes, response hold.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= StIdle;
      r_id        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else if (w_expired) begin
      // Abort: drop every valid/ready so late slave responses are never taken.
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RespDecErr;
      r_state     <= StResp;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_addr  <= i_cmd_addr;
            r_wdata <= i_cmd_wdata;
            r_wstrb <= i_cmd_wstrb;
            if (i_cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= StWr;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= StRd;
            end
          end
        end
        StWr: begin
          if (axi.awready) r_awvalid <= 1'b0;
          if (axi.wready) r_wvalid <= 1'b0;
          // Both channels done either earlier or on this edge.
          if ((!r_awvalid || axi.awready) && (!r_wvalid || axi.wready)) begin
            r_bready <= 1'b1;
            r_state  <= StWresp;
          end
        end
        StWresp: begin
          if (axi.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            if (axi.bid != r_id) r_rsp_resp <= RespSlvErr;
            else r_rsp_resp <= axi.bresp;
            r_state     <= StResp;
          end
        end
        StRd: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdata;
          end
        end
        StRdata: begin
          if (axi.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= axi.rdata;
            if (axi.rid != r_id) r_rsp_resp <= RespSlvErr;
            else r_rsp_resp <= RespOkay;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_id        <= r_id + {{(ID_W-1){1'b0}}, 1'b1};
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_reg_master.sv
// Directed bench for axi_reg_master with a small behavioural AXI register slave.
// Define AXI_MASTER_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=8).
module tb_axi_reg_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 256;
`endif

  logic        clk;
  logic        areset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;

  int total = 0;
  int bad   = 0;

  axi_reg_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  axi_reg_master #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT_CYC(TbTimeout)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp (o_rsp_resp),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model state
  logic [31:0] mem [0:15];
  logic [3:0]  bid_off = 4'd0;
  logic        s_aw_got, s_w_got, s_ar_got, b_hs, r_hs;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_awid, s_wstrb, s_arid;
  int          cyc = 0;
  int          aw_hs_cyc = 0;
  int          w_hs_cyc = 0;
  logic [3:0]  exp_id = 4'd0;

  // Slave: samples handshakes at posedge, updates its outputs at negedge.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    axi.awready = 1; axi.wready = 1; axi.arready = 1;
    axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (axi.awvalid && axi.awready) begin
        s_aw_got = 1; s_awaddr = axi.awaddr; s_awid = axi.awid; aw_hs_cyc = cyc;
      end
      if (axi.wvalid && axi.wready) begin
        s_w_got = 1; s_wdata = axi.wdata; s_wstrb = axi.wstrb; w_hs_cyc = cyc;
      end
      if (axi.arvalid && axi.arready) begin
        s_ar_got = 1; s_araddr = axi.araddr; s_arid = axi.arid;
      end
      b_hs = axi.bvalid && axi.bready;
      r_hs = axi.rvalid && axi.rready;
      @(negedge clk);
      if (b_hs) axi.bvalid = 0;
      if (r_hs) begin axi.rvalid = 0; axi.rlast = 0; end
      if (s_aw_got && s_w_got) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[3:0]][8*b +: 8] = s_wdata[8*b +: 8];
        axi.bvalid = 1; axi.bid = s_awid + bid_off; axi.bresp = 2'b00;
        s_aw_got = 0; s_w_got = 0;
      end
      if (s_ar_got) begin
        axi.rvalid = 1; axi.rid = s_arid; axi.rdata = mem[s_araddr[3:0]]; axi.rlast = 1;
        s_ar_got = 0;
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic ok);
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr;
    i_cmd_wdata = data; i_cmd_wstrb = strb;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (o_cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 i_cmd_valid = 0;
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_rsp_valid) begin ok = 1; break; end
    end
  endtask

  task automatic consume_rsp();
    @(negedge clk);
    i_rsp_ready = 1;
    @(posedge clk);
    #1 i_rsp_ready = 0;
    exp_id = exp_id + 4'd1;
  endtask

  task automatic test_reset();
    areset = 0;
    repeat (3) @(negedge clk);
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_ready got=%0b want=1", o_cmd_ready);
    end
    total++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, o_rsp_valid} !== 6'b0)
    begin
      bad++;
      $display("FAIL reset_valids got=%b want=000000",
               {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, o_rsp_valid});
    end
    total++;
    if ({axi.awid, axi.arid, axi.awaddr, axi.wdata} !== 72'h0) begin
      bad++; $display("FAIL reset_ids_addr got=%h want=0", {axi.awid, axi.awaddr, axi.wdata});
    end
    total++;
    if ({o_rsp_rdata, o_rsp_resp} !== 34'h0) begin
      bad++; $display("FAIL reset_rsp got=%h/%b want=0/00", o_rsp_rdata, o_rsp_resp);
    end
    areset = 1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic ok;
    do_cmd(1'b1, 32'd3, 32'hDEADBEEF, 4'hF, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL wr_accept got=%0b want=1", ok); end
    total++;
    if ({axi.awvalid, axi.wvalid, axi.wlast} !== 3'b111) begin
      bad++; $display("FAIL wr_valids got=%b want=111", {axi.awvalid, axi.wvalid, axi.wlast});
    end
    total++;
    if ({axi.awaddr, axi.wdata, axi.wstrb, axi.awid, axi.wid} !== {32'd3, 32'hDEADBEEF,
        4'hF, 4'd0, 4'd0}) begin
      bad++; $display("FAIL wr_payload got=%h %h %h id=%h want=3 deadbeef f 0",
                      axi.awaddr, axi.wdata, axi.wstrb, axi.awid);
    end
    wait_rsp(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL wr_rsp_timeout got=%0b want=1", ok); end
    total++;
    if ({o_rsp_resp, o_rsp_rdata} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL wr_rsp got=%b/%h want=00/0", o_rsp_resp, o_rsp_rdata);
    end
    total++;
    if (aw_hs_cyc !== w_hs_cyc) begin
      bad++; $display("FAIL wr_same_cycle aw=%0d w=%0d want equal", aw_hs_cyc, w_hs_cyc);
    end
    total++;
    if (mem[3] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_slave_reg3 got=%h want=deadbeef", mem[3]);
    end
    consume_rsp();
  endtask

  task automatic test_read();
    logic ok;
    do_cmd(1'b0, 32'd3, 32'h0, 4'h0, ok);
    total++;
    if ({ok, axi.arvalid, axi.arid, axi.araddr} !== {1'b1, 1'b1, 4'd1, 32'd3}) begin
      bad++; $display("FAIL rd_issue got=%b%b id=%h addr=%h want=11 1 3",
                      ok, axi.arvalid, axi.arid, axi.araddr);
    end
    wait_rsp(ok);
    total++;
    if ({ok, o_rsp_resp, o_rsp_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_rsp got=%b %b %h want=1 00 deadbeef", ok, o_rsp_resp, o_rsp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_aw_delay();
    logic ok;
    @(negedge clk);
    axi.awready = 0;
    do_cmd(1'b1, 32'd5, 32'h12345678, 4'h3, ok);
    total++;
    if ({axi.awvalid, axi.wvalid} !== 2'b11) begin
      bad++; $display("FAIL awd_start got=%b want=11", {axi.awvalid, axi.wvalid});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.awid} !== {2'b10, 32'd5, exp_id}) begin
        bad++; $display("FAIL awd_hold%0d got=%b%b addr=%h id=%h want=10 5 %h", k,
                        axi.awvalid, axi.wvalid, axi.awaddr, axi.awid, exp_id);
      end
    end
    axi.awready = 1;
    wait_rsp(ok);
    total++;
    if ({ok, o_rsp_resp} !== 3'b100) begin
      bad++; $display("FAIL awd_rsp got=%b %b want=1 00", ok, o_rsp_resp);
    end
    total++;
    if (mem[5] !== 32'h00005678) begin
      bad++; $display("FAIL awd_strobe_reg5 got=%h want=00005678", mem[5]);
    end
    consume_rsp();
    repeat (2) @(negedge clk);
    total++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL awd_single_rsp got=%b want=01", {o_rsp_valid, o_cmd_ready});
    end
  endtask

  task automatic test_rsp_hold();
    logic ok;
    do_cmd(1'b0, 32'd3, 32'h0, 4'h0, ok);
    wait_rsp(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL hold_rsp_timeout got=%0b want=1", ok); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({o_rsp_valid, o_cmd_ready, o_rsp_rdata, o_rsp_resp} !==
          {2'b10, 32'hDEADBEEF, 2'b00}) begin
        bad++; $display("FAIL hold_cyc%0d got=%b%b %h %b want=10 deadbeef 00", k,
                        o_rsp_valid, o_cmd_ready, o_rsp_rdata, o_rsp_resp);
      end
      @(negedge clk);
    end
    i_rsp_ready = 1;
    @(posedge clk);
    #1 i_rsp_ready = 0;
    exp_id = exp_id + 4'd1;
    total++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL hold_release got=%b want=01", {o_rsp_valid, o_cmd_ready});
    end
  endtask

  task automatic test_id_mismatch();
    logic ok;
    bid_off = 4'd1;
    do_cmd(1'b1, 32'd7, 32'hA5A5A5A5, 4'hF, ok);
    wait_rsp(ok);
    total++;
    if ({ok, o_rsp_resp, o_rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      bad++; $display("FAIL id_err got=%b %b %h want=1 10 0", ok, o_rsp_resp, o_rsp_rdata);
    end
    consume_rsp();
    bid_off = 4'd0;
  endtask

  task automatic test_id_wrap();
    logic ok;
    for (int n = 0; n < 16; n++) begin
      do_cmd(1'b0, 32'd3, 32'h0, 4'h0, ok);
      total++;
      if ({ok, axi.arid} !== {1'b1, exp_id}) begin
        bad++; $display("FAIL wrap_id%0d got=%b %h want=1 %h", n, ok, axi.arid, exp_id);
      end
      wait_rsp(ok);
      total++;
      if ({ok, o_rsp_resp} !== 3'b100) begin
        bad++; $display("FAIL wrap_rsp%0d got=%b %b want=1 00", n, ok, o_rsp_resp);
      end
      consume_rsp();
    end
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    int   hi;
    @(negedge clk);
    axi.arready = 0;
    do_cmd(1'b0, 32'd3, 32'h0, 4'h0, ok);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axi.arvalid) hi++;
      else break;
    end
    total++;
    if (hi !== 8) begin bad++; $display("FAIL to_arvalid_cycles got=%0d want=8", hi); end
    total++;
    if ({o_rsp_valid, o_rsp_resp, o_rsp_rdata, axi.rready} !== {1'b1, 2'b11, 32'h0, 1'b0})
    begin
      bad++; $display("FAIL to_rsp got=%b %b %h rr=%b want=1 11 0 0",
                      o_rsp_valid, o_rsp_resp, o_rsp_rdata, axi.rready);
    end
    consume_rsp();
    axi.arready = 1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1);
  end

  initial begin
    areset = 0; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0;
    i_cmd_wdata = 0; i_cmd_wstrb = 0; i_rsp_ready = 0;
    test_reset();
    test_write();
    test_read();
    test_aw_delay();
    test_rsp_hold();
    test_id_mismatch();
    test_id_wrap();
`ifdef AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
